serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (d = a - b), LSB first, registered borrow chain.
// Optional borrow-in port enabled by defining SERIAL_SUB_BIN_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CntW-1:0]  r_cnt;
  logic             r_br;

  logic             w_bin;
  logic             w_diff;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUB_BIN_EN
  assign w_bin = bin;
`else
  assign w_bin = 1'b0;
`endif

  // One full-subtractor cell applied to the current LSB pair.
  assign w_diff     = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

  assign busy = (r_state != StIdle);
  assign done = (r_state == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      d       <= '0;
      bout    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= w_bin;
            r_cnt   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          // Outputs only move on the final bit so d/bout stay stable during RUN.
          if (r_cnt == CntLast) begin
            d       <= w_res_next;
            bout    <= w_br_next;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor, checked against an arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin_s;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  int checks;
  int failures;

  logic [W-1:0] exp_d_last;
  logic         exp_bout_last;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_BIN_EN
    .bin   (bin_s),
`endif
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation; repulse pokes start during RUN and DONE to prove it is ignored.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       input bit repulse);
    logic [W:0] full;
    int k;
    full = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    bin_s = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin_s = 1'($urandom);
    k = 0;
    while (!done && k <= int'(W) + 2) begin
      check_eq("busy_run", 32'(busy), 32'd1);
      check_eq("d_hold", 32'(d), 32'(exp_d_last));
      check_eq("bout_hold", 32'(bout), 32'(exp_bout_last));
      if (repulse && k == 2) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    check_eq("latency", 32'(k), 32'(W));
    check_eq("done", 32'(done), 32'd1);
    check_eq("busy_done", 32'(busy), 32'd1);
    check_eq("d", 32'(d), 32'(full[W-1:0]));
    check_eq("bout", 32'(bout), 32'(full[W]));
    exp_d_last    = full[W-1:0];
    exp_bout_last = full[W];
    if (repulse) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    if (repulse) begin
      @(posedge clk);
      #1;
      check_eq("no_restart_busy", 32'(busy), 32'd0);
      check_eq("no_restart_d", 32'(d), 32'(exp_d_last));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic bi;
    checks        = 0;
    failures      = 0;
    exp_d_last    = '0;
    exp_bout_last = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin_s = 1'b0;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_d", 32'(d), 32'd0);
    check_eq("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h35, 8'h12, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0);
    do_op(8'h35, 8'h12, 1'b0, 1'b1);
    do_op(8'h35, 8'h12, 1'b0, 1'b0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0);

    // Abort on the 4th RUN cycle with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h35;
    b     = 8'h12;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_d", 32'(d), 32'd0);
    check_eq("abort_bout", 32'(bout), 32'd0);
    exp_d_last    = '0;
    exp_bout_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
    do_op(8'h35, 8'h12, 1'b0, 1'b0);

`ifdef SERIAL_SUB_BIN_EN
    do_op(8'h10, 8'h10, 1'b1, 1'b0);
    do_op(8'h10, 8'h10, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_SUB_BIN_EN
      bi = 1'($urandom);
`else
      bi = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), bi, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
